instr_queue: RTL and testbench
==============================

// Module: instr_queue
// PURPOSE
//   Instruction queue between fetch and decode. Buffers whole fetched x86 instructions
//   ({bytes, length, pc}) so fetch can run ahead of decode. Its input side is the fetch
//   result handshake; its output side feeds the decoder. Branch redirects from
//   writeback flush it.
// PARAMETERS
//   DEPTH        4                  entries; power of two, >= 2
//   ADDR_W       `ADDRESS_WIDTH     pc width (32)
//   INSTR_W      `MAX_INSTR_WIDTH   instruction byte vector width (120 = 15 B)
// PORTS
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous, active-low; clears all state
//   i_res_valid  in   1        fetch: instr/len/pc valid
//   i_instr      in   INSTR_W  fetch: instruction bytes, byte 0 in [7:0]
//   i_instr_len  in   4        fetch: length in bytes, 1..15
//   i_pc         in   ADDR_W   fetch: address of byte 0
//   o_dec_ready  out  1        to fetch: queue can accept (not full, not flushing)
//   i_flush      in   1        writeback redirect (i_pc_valid); discard all entries
//   o_valid      out  1        to decoder: head entry valid
//   o_instr      out  INSTR_W  head instruction bytes; 0 when !o_valid
//   o_instr_len  out  4        head length; 0 when !o_valid
//   o_pc         out  ADDR_W   head pc; 0 when !o_valid
//   i_ready      in   1        decoder accepts head this cycle
//   o_count      out  log2(DEPTH)+1  occupied entries
//   o_len_err    out  1        1-cycle pulse: an offered entry with length 0 was dropped
// BEHAVIOUR
//   Reset (reset==0, async): wr_ptr = rd_ptr = 0, count = 0. Outputs: o_valid = 0,
//     o_dec_ready = 0, o_len_err = 0, o_count = 0, and data outputs 0. Storage is not
//     cleared. Any transfer in flight is lost.
//   First cycle after reset release: o_dec_ready = 1.
//   Push: on a rising edge with i_res_valid && o_dec_ready && i_instr_len != 0, write
//     {i_instr, i_instr_len, i_pc} at wr_ptr, then wr_ptr++ (wraps modulo DEPTH).
//     Upstream holds its data until it sees a push; one edge with valid&&ready = one entry.
//   Length 0: the handshake completes (fetch is released), nothing is stored, and
//     o_len_err pulses high for the next cycle.
//   Pop: on a rising edge with o_valid && i_ready, rd_ptr++ (wraps).
//   o_valid = (count != 0). Head outputs are driven from storage[rd_ptr] and gated to 0
//     when !o_valid.
//   Latency: an entry pushed at edge N is visible at the outputs after edge N.
//     There is no same-cycle bypass when empty.
//   o_dec_ready = (count < DEPTH) && !i_flush && reset.
//     Full: no push, even if a pop occurs in the same cycle.
//   Push and pop on the same edge: count is unchanged and both pointers advance.
//     When count == 1 the new entry becomes the head.
//   Flush (i_flush high at an edge): count, wr_ptr and rd_ptr go to 0. Flush wins over
//     a simultaneous push and pop. o_valid = 0 on the following cycle. A pop presented
//     on the flush edge is still counted as taken by the decoder.
//   o_count is registered, 0..DEPTH. It never overflows or underflows; a pop with
//     count == 0 is impossible because o_valid gates it.
//   Pointers are log2(DEPTH) bits wide. Full/empty is resolved by count, not by pointer
//     comparison.
// TESTING
//   1. Reset low mid-stream with 2 entries held -> o_valid = 0 and o_count = 0
//      immediately (async); o_dec_ready = 1 one cycle after release.
//   2. Push pc = 0x100 len 3, then 0x103 len 2, with i_ready = 0 -> o_count = 2,
//      head = 0x100/3. Raise i_ready -> heads 0x100, then 0x103, then o_valid = 0.
//   3. Push 4 entries with i_ready = 0 -> o_dec_ready = 0 at o_count = 4. A fifth offer
//      is held. One pop -> fifth accepted next edge. Order is preserved across pointer wrap.
//   4. count = 2, push and pop on the same edge -> o_count stays 2; the popped head
//      changes to the next entry.
//   5. count = 3, i_flush with simultaneous push -> o_count = 0, o_valid = 0, pushed
//      entry absent. Next push pc = 0x200 becomes head.
//   6. Offer len = 0 -> handshake taken, o_len_err = 1 for one cycle, o_count unchanged.

Source files
------------

// File: rtl/instr_queue_if.sv
// Fetch-to-decode instruction queue signal bundle.
// The slave modport is the queue side; master is the fetch/decode/writeback environment.
interface instr_queue_if #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INSTR_W = 120
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic               i_res_valid;
   logic [INSTR_W-1:0] i_instr;
   logic [3:0]         i_instr_len;
   logic [ADDR_W-1:0]  i_pc;
   logic               o_dec_ready;
   logic               i_flush;
   logic               o_valid;
   logic [INSTR_W-1:0] o_instr;
   logic [3:0]         o_instr_len;
   logic [ADDR_W-1:0]  o_pc;
   logic               i_ready;
   logic [CNT_W-1:0]   o_count;
   logic               o_len_err;

   modport slave (
      input  i_res_valid, i_instr, i_instr_len, i_pc, i_flush, i_ready,
      output o_dec_ready, o_valid, o_instr, o_instr_len, o_pc, o_count, o_len_err
   );

   modport master (
      output i_res_valid, i_instr, i_instr_len, i_pc, i_flush, i_ready,
      input  o_dec_ready, o_valid, o_instr, o_instr_len, o_pc, o_count, o_len_err
   );
endinterface

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: buffers whole {bytes, length, pc} entries,
// flushed on writeback redirect. Full/empty come from the occupancy count.
module instr_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INSTR_W = 120
) (
   input logic          clk,
   input logic          reset,
   instr_queue_if.slave q
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [INSTR_W-1:0] mem_instr [DEPTH];
   logic [3:0]         mem_len   [DEPTH];
   logic [ADDR_W-1:0]  mem_pc    [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             len_err;

   logic dec_ready;
   logic valid;
   logic handshake;
   logic push;
   logic pop;

   always_comb begin
      dec_ready = (count < CNT_W'(DEPTH)) && !q.i_flush && reset;
      valid     = (count != '0);
      handshake = q.i_res_valid && dec_ready;
      push      = handshake && (q.i_instr_len != 4'd0);
      pop       = valid && q.i_ready;
   end

   // Storage carries no reset; only pointers and count define what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= q.i_instr;
         mem_len[wr_ptr]   <= q.i_instr_len;
         mem_pc[wr_ptr]    <= q.i_pc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         len_err <= 1'b0;
      end else begin
         // A zero-length offer completes the handshake but is only reported, never stored.
         len_err <= handshake && (q.i_instr_len == 4'd0);
         if (q.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

   always_comb begin
      q.o_dec_ready = dec_ready;
      q.o_valid     = valid;
      q.o_count     = count;
      q.o_len_err   = len_err;
      q.o_instr     = valid ? mem_instr[rd_ptr] : '0;
      q.o_instr_len = valid ? mem_len[rd_ptr]   : '0;
      q.o_pc        = valid ? mem_pc[rd_ptr]    : '0;
   end
endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: reset, ordering, full/wrap, push+pop, flush, zero length.
module tb_instr_queue;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   instr_queue_if #(.DEPTH(4), .ADDR_W(32), .INSTR_W(120)) q ();

   instr_queue #(.DEPTH(4), .ADDR_W(32), .INSTR_W(120)) dut (
      .clk   (clk),
      .reset (reset),
      .q     (q)
   );

   always #5 clk = ~clk;

   function automatic logic [119:0] mk(input logic [31:0] pc);
      return {pc, ~pc, pc ^ 32'h5A5A5A5A, 24'hC3C3C3};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] pc, input logic [3:0] len);
      q.i_res_valid = 1'b1;
      q.i_pc        = pc;
      q.i_instr     = mk(pc);
      q.i_instr_len = len;
   endtask

   task automatic push(input logic [31:0] pc, input logic [3:0] len);
      offer(pc, len);
      tick();
      q.i_res_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      q.i_res_valid = 1'b0; q.i_instr = '0; q.i_instr_len = '0; q.i_pc = '0;
      q.i_flush = 1'b0; q.i_ready = 1'b0;
      #1;
      total++; if (q.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", q.o_valid); end
      total++; if (q.o_dec_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", q.o_dec_ready); end
      total++; if (q.o_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", q.o_count); end
      total++; if (q.o_len_err !== 1'b0) begin bad++; $display("FAIL rst_len_err: got %b want 0", q.o_len_err); end
      total++; if ({q.o_pc, q.o_instr_len, q.o_instr} !== '0) begin bad++; $display("FAIL rst_data: got %0h/%0h want 0", q.o_pc, q.o_instr_len); end
      tick();
      reset = 1'b1;
      #1;
      total++; if (q.o_dec_ready !== 1'b1) begin bad++; $display("FAIL rel_ready: got %b want 1", q.o_dec_ready); end
   endtask

   task automatic test_reset_midstream();
      push(32'h0000_0010, 4'd1);
      push(32'h0000_0011, 4'd2);
      total++; if (q.o_count !== 3'd2) begin bad++; $display("FAIL mid_count_pre: got %0d want 2", q.o_count); end
      #2 reset = 1'b0;
      #1;
      total++; if (q.o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", q.o_valid); end
      total++; if (q.o_count !== 3'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", q.o_count); end
      total++; if (q.o_dec_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_low: got %b want 0", q.o_dec_ready); end
      tick();
      reset = 1'b1;
      tick();
      total++; if (q.o_dec_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_rel: got %b want 1", q.o_dec_ready); end
      total++; if (q.o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid_rel: got %b want 0", q.o_valid); end
   endtask

   task automatic test_order();
      q.i_ready = 1'b0;
      push(32'h100, 4'd3);
      push(32'h103, 4'd2);
      total++; if (q.o_count !== 3'd2) begin bad++; $display("FAIL ord_count: got %0d want 2", q.o_count); end
      total++; if (q.o_pc !== 32'h100 || q.o_instr_len !== 4'd3) begin bad++; $display("FAIL ord_head0: got %0h/%0d want 100/3", q.o_pc, q.o_instr_len); end
      total++; if (q.o_instr !== mk(32'h100)) begin bad++; $display("FAIL ord_instr0: got %0h want %0h", q.o_instr, mk(32'h100)); end
      q.i_ready = 1'b1;
      tick();
      total++; if (q.o_pc !== 32'h103 || q.o_instr_len !== 4'd2) begin bad++; $display("FAIL ord_head1: got %0h/%0d want 103/2", q.o_pc, q.o_instr_len); end
      total++; if (q.o_count !== 3'd1) begin bad++; $display("FAIL ord_count1: got %0d want 1", q.o_count); end
      tick();
      total++; if (q.o_valid !== 1'b0) begin bad++; $display("FAIL ord_empty: got %b want 0", q.o_valid); end
      total++; if ({q.o_pc, q.o_instr_len, q.o_instr} !== '0) begin bad++; $display("FAIL ord_gate: got %0h/%0h want 0", q.o_pc, q.o_instr_len); end
      q.i_ready = 1'b0;
   endtask

   task automatic test_full_wrap();
      logic [31:0] exp_pc  [4] = '{32'h20, 32'h30, 32'h40, 32'h50};
      logic [3:0]  exp_len [4] = '{4'd2, 4'd3, 4'd4, 4'd5};
      push(32'h10, 4'd1);
      push(32'h20, 4'd2);
      push(32'h30, 4'd3);
      push(32'h40, 4'd4);
      total++; if (q.o_count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", q.o_count); end
      total++; if (q.o_dec_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", q.o_dec_ready); end
      offer(32'h50, 4'd5);
      tick();
      total++; if (q.o_count !== 3'd4) begin bad++; $display("FAIL full_held: got %0d want 4", q.o_count); end
      total++; if (q.o_pc !== 32'h10) begin bad++; $display("FAIL full_head: got %0h want 10", q.o_pc); end
      q.i_ready = 1'b1;
      tick();
      q.i_ready = 1'b0;
      total++; if (q.o_count !== 3'd3) begin bad++; $display("FAIL full_pop_no_push: got %0d want 3", q.o_count); end
      total++; if (q.o_dec_ready !== 1'b1) begin bad++; $display("FAIL full_ready_again: got %b want 1", q.o_dec_ready); end
      tick();
      q.i_res_valid = 1'b0;
      total++; if (q.o_count !== 3'd4) begin bad++; $display("FAIL full_fifth: got %0d want 4", q.o_count); end
      for (int unsigned k = 0; k < 4; k++) begin
         total++;
         if (q.o_valid !== 1'b1 || q.o_pc !== exp_pc[k] || q.o_instr_len !== exp_len[k] || q.o_instr !== mk(exp_pc[k])) begin
            bad++; $display("FAIL wrap_head%0d: got %0h/%0d want %0h/%0d", k, q.o_pc, q.o_instr_len, exp_pc[k], exp_len[k]);
         end
         q.i_ready = 1'b1;
         tick();
      end
      q.i_ready = 1'b0;
      total++; if (q.o_valid !== 1'b0 || q.o_count !== 3'd0) begin bad++; $display("FAIL wrap_drained: got %b/%0d want 0/0", q.o_valid, q.o_count); end
   endtask

   task automatic test_back_to_back();
      push(32'h300, 4'd1);
      push(32'h301, 4'd2);
      offer(32'h302, 4'd3);
      q.i_ready = 1'b1;
      tick();
      q.i_res_valid = 1'b0;
      q.i_ready = 1'b0;
      total++; if (q.o_count !== 3'd2) begin bad++; $display("FAIL b2b_count: got %0d want 2", q.o_count); end
      total++; if (q.o_pc !== 32'h301 || q.o_instr_len !== 4'd2) begin bad++; $display("FAIL b2b_head: got %0h/%0d want 301/2", q.o_pc, q.o_instr_len); end
   endtask

   task automatic test_flush();
      push(32'h303, 4'd4);
      total++; if (q.o_count !== 3'd3) begin bad++; $display("FAIL fl_pre: got %0d want 3", q.o_count); end
      offer(32'h304, 4'd5);
      q.i_ready = 1'b1;
      q.i_flush = 1'b1;
      #1;
      total++; if (q.o_dec_ready !== 1'b0) begin bad++; $display("FAIL fl_ready: got %b want 0", q.o_dec_ready); end
      tick();
      q.i_flush = 1'b0;
      q.i_res_valid = 1'b0;
      q.i_ready = 1'b0;
      total++; if (q.o_count !== 3'd0 || q.o_valid !== 1'b0) begin bad++; $display("FAIL fl_empty: got %0d/%b want 0/0", q.o_count, q.o_valid); end
      total++; if (q.o_pc !== 32'h0) begin bad++; $display("FAIL fl_pc: got %0h want 0", q.o_pc); end
      push(32'h200, 4'd6);
      total++; if (q.o_pc !== 32'h200 || q.o_instr_len !== 4'd6 || q.o_count !== 3'd1) begin bad++; $display("FAIL fl_new_head: got %0h/%0d/%0d want 200/6/1", q.o_pc, q.o_instr_len, q.o_count); end
      q.i_ready = 1'b1;
      tick();
      q.i_ready = 1'b0;
      total++; if (q.o_valid !== 1'b0) begin bad++; $display("FAIL fl_no_stale: got %b want 0", q.o_valid); end
   endtask

   task automatic test_len_zero();
      push(32'h400, 4'd2);
      total++; if (q.o_len_err !== 1'b0) begin bad++; $display("FAIL lz_idle: got %b want 0", q.o_len_err); end
      offer(32'h500, 4'd0);
      #1;
      total++; if (q.o_dec_ready !== 1'b1) begin bad++; $display("FAIL lz_ready: got %b want 1", q.o_dec_ready); end
      tick();
      q.i_res_valid = 1'b0;
      total++; if (q.o_len_err !== 1'b1) begin bad++; $display("FAIL lz_pulse: got %b want 1", q.o_len_err); end
      total++; if (q.o_count !== 3'd1) begin bad++; $display("FAIL lz_count: got %0d want 1", q.o_count); end
      tick();
      total++; if (q.o_len_err !== 1'b0) begin bad++; $display("FAIL lz_pulse_end: got %b want 0", q.o_len_err); end
      total++; if (q.o_pc !== 32'h400 || q.o_instr_len !== 4'd2) begin bad++; $display("FAIL lz_head: got %0h/%0d want 400/2", q.o_pc, q.o_instr_len); end
      q.i_ready = 1'b1;
      tick();
      q.i_ready = 1'b0;
      total++; if (q.o_valid !== 1'b0) begin bad++; $display("FAIL lz_not_stored: got %b want 0", q.o_valid); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_reset_midstream();
      test_order();
      test_full_wrap();
      test_back_to_back();
      test_flush();
      test_len_zero();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
